// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types, state encodings, size codes and kseg mapping
//                helper for the memory bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  // Owner of the single outstanding transaction
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Access size encodings shared by requesters and bus
  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [1:0] c_size_word = 2'd2;

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto the low 512 MB
  function automatic logic [31:0] kseg_map(input logic [31:0] vaddr);
    if (vaddr[31:30] == 2'b10) begin
      return {3'b000, vaddr[28:0]};
    end
    return vaddr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kseg_addr_map.sv
`default_nettype none
// ============================================================================
//  Module      : kseg_addr_map
//  Description : Combinational virtual-to-physical translator for kseg0/kseg1,
//                or a plain pass-through when ADDR_MAP is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module kseg_addr_map
  import mem_bus_pkg::*;
#(
  parameter int ADDR_MAP = 1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  generate
    if (ADDR_MAP != 0) begin : g_map
      // Translate kseg0/kseg1 to physical
      assign paddr = kseg_map(vaddr);
    end else begin : g_pass
      // Addresses already physical
      assign paddr = vaddr;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one SRAM-like bus between instruction fetch and data
//                access; one transaction outstanding, data priority with a
//                fetch starvation guard, response routed to the owner only.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_MAP     = 1
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction fetch requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // downstream bus
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [1:0]  r_state;
  logic [3:0]  r_starve_cnt;
  owner_t      r_owner;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_idle;
  logic        w_grant_data;
  logic        w_grant_inst;
  logic        w_resp_done;

  // Grants are only offered in IDLE and never while reset is held, so every
  // output stays low during reset even with requests pending.
  assign w_idle       = (r_state == c_st_idle) && resetn;
  assign w_grant_data = w_idle && data_req && (!inst_req || (r_starve_cnt < c_starve_limit));
  assign w_grant_inst = w_idle && !w_grant_data && inst_req;
  assign w_resp_done  = (r_state == c_st_resp) && bus_data_ok;

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  assign inst_data_ok = w_resp_done && (r_owner == OWN_INST);
  assign data_data_ok = w_resp_done && (r_owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? bus_rdata : 32'h0;

  assign bus_req   = (r_state == c_st_req);
  assign bus_wr    = r_wr;
  assign bus_size  = r_size;
  assign bus_wdata = r_wdata;
  assign busy      = (r_state != c_st_idle);

  kseg_addr_map #(
    .ADDR_MAP (ADDR_MAP)
  ) u_map (
    .vaddr (r_addr),
    .paddr (bus_addr)
  );

  // Transaction FSM: IDLE -> REQ on grant, REQ -> RESP on accept, RESP -> IDLE on response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (w_grant_data || w_grant_inst) r_state <= c_st_req;
        c_st_req:  if (bus_addr_ok)                  r_state <= c_st_resp;
        c_st_resp: if (bus_data_ok)                  r_state <= c_st_idle;
        default:                                     r_state <= c_st_idle;
      endcase
    end
  end

  // Capture the winning request; fetch is always a word read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner <= OWN_INST;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (w_grant_data) begin
      r_owner <= OWN_DATA;
      r_wr    <= data_wr;
      r_size  <= data_size;
      r_addr  <= data_addr;
      r_wdata <= data_wdata;
    end else if (w_grant_inst) begin
      r_owner <= OWN_INST;
      r_wr    <= 1'b0;
      r_size  <= c_size_word;
      r_addr  <= inst_addr;
      r_wdata <= 32'h0;
    end
  end

  // Count data grants made over a waiting fetch; a fetch grant clears it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_inst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_data && inst_req && (r_starve_cnt < c_starve_limit)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single SRAM-like memory bus port between the instruction-fetch requester (PC/IF stage) and the data requester (MEM stage lw/sw). It holds at most one transaction outstanding, grants data over fetch with a starvation guard, and translates kseg0/kseg1 virtual addresses to physical. It routes each response back only to the requester that owns the transaction.

## Interface
- STARVE_LIMIT, 4: consecutive data grants that may be made while a fetch is pending; 1..15.
- ADDR_MAP, 1: 1 = kseg0/kseg1 address translation enabled; 0 = pass addresses through unchanged.

- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req / inst_addr  in  1/32  fetch request and address (read only, word size).
- inst_addr_ok / inst_data_ok  out  1/1  fetch request accepted / fetch data valid.
- inst_rdata  out  32  fetched instruction.
- data_req / data_wr / data_size  in  1/1/2  data request, write flag, and size (0=byte, 1=half, 2=word).
- data_addr / data_wdata  in  32/32  data address and write data.
- data_addr_ok / data_data_ok  out  1/1  data request accepted / data response (read data or write done).
- data_rdata  out  32  load data.
- bus_req / bus_wr / bus_size  out  1/1/2  downstream request, write flag, and size.
- bus_addr / bus_wdata  out  32/32  downstream physical address and write data.
- bus_addr_ok / bus_data_ok  in  1/1  downstream accept / response.
- bus_rdata  in  32  downstream read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, REQ, RESP.
- IDLE, grant decision (combinational):
  - If data_req is high and (inst_req is low or starve_cnt < STARVE_LIMIT), grant data.
  - Otherwise, if inst_req is high, grant fetch.
  - The granted requester sees its *_addr_ok = 1 in the same cycle.
  - Its request fields are latched, owner is latched, and the FSM moves to REQ.
  - The ungranted requester's addr_ok stays 0; it must hold its request.
- REQ:
  - bus_req = 1 and bus_* are driven from the latched fields.
  - On bus_addr_ok, move to RESP.
- RESP:
  - bus_req = 0.
  - On bus_data_ok, pulse owner's *_data_ok for that cycle and pass bus_rdata to owner's *_rdata; move to IDLE.
- Fetch latch always sets wr=0 and size=2.
- starve_cnt is 4 bits:
  - Increments (saturating at STARVE_LIMIT) on a data grant while inst_req = 1.
  - Clears on any fetch grant.
  - Holds otherwise.
- Address map, when ADDR_MAP = 1:
  - If addr[31:30] == 2'b10, then bus_addr = {3'b000, addr[28:0]}.
  - Otherwise bus_addr = addr.
- The non-owner's *_data_ok is never asserted. *_rdata for a requester that is not receiving data_ok = 0.
- bus_data_ok arriving in IDLE or REQ is ignored.
- bus_addr_ok arriving outside REQ is ignored.

## Timing
- Reset values:
  - state = IDLE, starve_cnt = 0, latched fields = 0, owner = fetch.
  - All outputs 0: bus_req, bus_wr, bus_size, bus_addr, bus_wdata, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, inst_rdata, data_rdata, busy.
- Minimum occupancy is 3 cycles:
  - cycle 0: addr_ok.
  - cycle 1: bus_req with bus_addr_ok.
  - cycle 2: bus_data_ok → owner data_ok.
  - cycle 3: earliest next grant.
- No new grant is made in the data_ok cycle.
- bus_req stays high, with stable fields, every cycle from entering REQ until bus_addr_ok inclusive.
- Simultaneous inst_req and data_req in IDLE: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- resetn asserted mid-transaction returns the block immediately to IDLE with bus_req = 0. A late bus_data_ok after that is ignored.
- Request inputs are sampled only in IDLE. Changes to them in other states have no effect.

## Structure
- Shared package `mem_bus_pkg` holds:
  - state enum (IDLE/REQ/RESP).
  - owner enum (OWN_INST/OWN_DATA).
  - size encodings.
  - kseg mapping function.
- Sub-module `kseg_addr_map`: the combinational ADDR_MAP translator, reusable by a later TLB-less data path.

## Test plan
- Reset, then fetch only:
  - Stimulus: inst_req = 1, inst_addr = 0xbfc00000; bus gives addr_ok in cycle 1 and data_ok in cycle 2 with rdata = 0x3c080001.
  - Response: bus_addr = 0x1fc00000; inst_data_ok in cycle 2 with inst_rdata = 0x3c080001; data_data_ok stays 0.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (lw, 0x80001000) both held.
  - Response: data granted first with bus_addr = 0x00001000 and bus_wr = 0; fetch granted on the next IDLE.
- Starvation guard:
  - Stimulus: inst_req held; data_req held continuously; STARVE_LIMIT = 4.
  - Response: exactly 4 data grants, then 1 fetch grant, then data again.
- Store:
  - Stimulus: data_wr = 1, size = 0, addr = 0x1faf0000 (no mapping), wdata = 0xa5.
  - Response: bus fields match exactly; bus_req holds through 3 cycles of bus_addr_ok = 0.
- Reset mid-operation:
  - Stimulus: resetn pulled low in RESP, then bus_data_ok after release.
  - Response: all outputs 0, state IDLE, and no data_ok to either requester.
- ADDR_MAP = 0:
  - Stimulus: addr 0xbfc00000.
  - Response: bus_addr = 0xbfc00000.
